// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - default geometry and feature constants for the register file
package regfile_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_ADDR_W   = 3;
    localparam int DEF_ZERO_REG = 1;
    localparam int DEF_BYPASS   = 1;
    localparam int DEF_DEPTH    = 2 ** DEF_ADDR_W;

endpackage

// File: rtl/regfile_if.sv
// rtl/regfile_if.sv - two write ports, two read ports and the collision flag
interface regfile_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) ();

    logic              regwrite;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic              regwrite2;
    logic [ADDR_W-1:0] wa2;
    logic [DATA_W-1:0] wd2;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              wcoll;

    modport master (
        output regwrite, wa, wd, regwrite2, wa2, wd2, ra1, ra2,
        input  rd1, rd2, wcoll
    );

    modport slave (
        input  regwrite, wa, wd, regwrite2, wa2, wd2, ra1, ra2,
        output rd1, rd2, wcoll
    );

endinterface

// File: rtl/regfile_bypass.sv
// rtl/regfile_bypass.sv - per-read-port write forwarding and register-zero mux
module regfile_bypass
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = DEF_ZERO_REG,
    parameter int BYPASS   = DEF_BYPASS
) (
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra,
    input  logic [DATA_W-1:0] stored,
    input  logic              regwrite,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              regwrite2,
    input  logic [ADDR_W-1:0] wa2,
    input  logic [DATA_W-1:0] wd2,
    output logic [DATA_W-1:0] rd
);

    // Port 1 is applied last so it wins, mirroring which port gets stored on a collision.
    always_comb begin
        rd = stored;
        if (BYPASS != 0 && !rst) begin
            if (regwrite2 && wa2 == ra) rd = wd2;
            if (regwrite && wa == ra)   rd = wd;
        end
        if (ZERO_REG != 0 && ra == '0) rd = '0;
    end

endmodule

// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parameterised 2-write/2-read register file with collision flag
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = DEF_ZERO_REG,
    parameter int BYPASS   = DEF_BYPASS
) (
    input  logic     clk,
    input  logic     rst,
    regfile_if.slave bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              coll;
    logic              wr1_en;
    logic              wr2_en;
    logic              wcoll_q;

    // A collision at address 0 still counts even though nothing gets stored there.
    always_comb begin
        coll   = bus.regwrite && bus.regwrite2 && (bus.wa == bus.wa2);
        wr1_en = bus.regwrite && !(ZERO_REG != 0 && bus.wa == '0);
        wr2_en = bus.regwrite2 && !coll && !(ZERO_REG != 0 && bus.wa2 == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            wcoll_q <= 1'b0;
        end else begin
            if (wr1_en) regs[bus.wa]  <= bus.wd;
            if (wr2_en) regs[bus.wa2] <= bus.wd2;
            wcoll_q <= coll;
        end
    end

    assign bus.wcoll = wcoll_q;

    regfile_bypass #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_byp1 (
        .rst       (rst),
        .ra        (bus.ra1),
        .stored    (regs[bus.ra1]),
        .regwrite  (bus.regwrite),
        .wa        (bus.wa),
        .wd        (bus.wd),
        .regwrite2 (bus.regwrite2),
        .wa2       (bus.wa2),
        .wd2       (bus.wd2),
        .rd        (bus.rd1)
    );

    regfile_bypass #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_byp2 (
        .rst       (rst),
        .ra        (bus.ra2),
        .stored    (regs[bus.ra2]),
        .regwrite  (bus.regwrite),
        .wa        (bus.wa),
        .wd        (bus.wd),
        .regwrite2 (bus.regwrite2),
        .wa2       (bus.wa2),
        .wd2       (bus.wd2),
        .rd        (bus.rd2)
    );

endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - scoreboard bench: default config and a 16-bit/16-deep no-bypass config
module tb_regfile_param;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_if #(.DATA_W(8),  .ADDR_W(3)) bus_a ();
    regfile_if #(.DATA_W(16), .ADDR_W(4)) bus_b ();

    regfile_param dut_a (.clk(clk), .rst(rst), .bus(bus_a));

    regfile_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1), .BYPASS(0)) dut_b (
        .clk (clk), .rst (rst), .bus (bus_b)
    );

    typedef struct {
        logic [7:0]  a_rd1, a_rd2;
        logic        a_wc;
        logic [15:0] b_rd1, b_rd2;
        logic        b_wc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference contents of both register files after the most recent edge.
    logic [7:0]  mem_a [8];
    logic [15:0] mem_b [16];
    logic        coll_a, coll_b;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("a_rd1", {8'h0, bus_a.rd1}, {8'h0, e.a_rd1});
            chk("a_rd2", {8'h0, bus_a.rd2}, {8'h0, e.a_rd2});
            chk("a_wcoll", {15'h0, bus_a.wcoll}, {15'h0, e.a_wc});
            chk("b_rd1", bus_b.rd1, e.b_rd1);
            chk("b_rd2", bus_b.rd2, e.b_rd2);
            chk("b_wcoll", {15'h0, bus_b.wcoll}, {15'h0, e.b_wc});
        end
    end

    // Config A forwards same-cycle writes (port 1 first); config B only ever shows storage.
    function automatic logic [15:0] model_rd(input bit is_b, input logic r,
            input logic w1, input logic [3:0] a1, input logic [15:0] d1,
            input logic w2, input logic [3:0] a2, input logic [15:0] d2,
            input logic [3:0] ra);
        logic [15:0] v;
        if (is_b) begin
            if (ra == 4'd0) return 16'h0;
            return mem_b[ra];
        end
        if (ra[2:0] == 3'd0) return 16'h0;
        v = {8'h0, mem_a[ra[2:0]]};
        if (!r) begin
            if (w1 && a1[2:0] == ra[2:0])      v = {8'h0, d1[7:0]};
            else if (w2 && a2[2:0] == ra[2:0]) v = {8'h0, d2[7:0]};
        end
        return v;
    endfunction

    task automatic step(input logic r, input logic w1, input logic [3:0] a1, input logic [15:0] d1,
            input logic w2, input logic [3:0] a2, input logic [15:0] d2,
            input logic [3:0] r1, input logic [3:0] r2);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        bus_a.regwrite = w1; bus_a.wa = a1[2:0]; bus_a.wd = d1[7:0];
        bus_a.regwrite2 = w2; bus_a.wa2 = a2[2:0]; bus_a.wd2 = d2[7:0];
        bus_a.ra1 = r1[2:0]; bus_a.ra2 = r2[2:0];
        bus_b.regwrite = w1; bus_b.wa = a1; bus_b.wd = d1;
        bus_b.regwrite2 = w2; bus_b.wa2 = a2; bus_b.wd2 = d2;
        bus_b.ra1 = r1; bus_b.ra2 = r2;
        e.a_rd1 = model_rd(0, r, w1, a1, d1, w2, a2, d2, r1) & 16'h00FF;
        e.a_rd2 = model_rd(0, r, w1, a1, d1, w2, a2, d2, r2) & 16'h00FF;
        e.b_rd1 = model_rd(1, r, w1, a1, d1, w2, a2, d2, r1);
        e.b_rd2 = model_rd(1, r, w1, a1, d1, w2, a2, d2, r2);
        e.a_wc  = coll_a;
        e.b_wc  = coll_b;
        sb.push_back(e);
        if (r) begin
            foreach (mem_a[i]) mem_a[i] = '0;
            foreach (mem_b[i]) mem_b[i] = '0;
            coll_a = 1'b0;
            coll_b = 1'b0;
        end else begin
            coll_a = w1 && w2 && (a1[2:0] == a2[2:0]);
            coll_b = w1 && w2 && (a1 == a2);
            if (w2 && !coll_a && a2[2:0] != 3'd0) mem_a[a2[2:0]] = d2[7:0];
            if (w1 && a1[2:0] != 3'd0)            mem_a[a1[2:0]] = d1[7:0];
            if (w2 && !coll_b && a2 != 4'd0)      mem_b[a2] = d2;
            if (w1 && a1 != 4'd0)                 mem_b[a1] = d1;
        end
    endtask

    task automatic idle(input logic [3:0] r1, input logic [3:0] r2);
        step(0, 0, 0, 0, 0, 0, 0, r1, r2);
    endtask

    initial begin
        rst = 1'b1;
        bus_a.regwrite = 0; bus_a.wa = 0; bus_a.wd = 0;
        bus_a.regwrite2 = 0; bus_a.wa2 = 0; bus_a.wd2 = 0; bus_a.ra1 = 0; bus_a.ra2 = 0;
        bus_b.regwrite = 0; bus_b.wa = 0; bus_b.wd = 0;
        bus_b.regwrite2 = 0; bus_b.wa2 = 0; bus_b.wd2 = 0; bus_b.ra1 = 0; bus_b.ra2 = 0;
        foreach (mem_a[i]) mem_a[i] = '0;
        foreach (mem_b[i]) mem_b[i] = '0;
        coll_a = 0;
        coll_b = 0;
        repeat (2) @(posedge clk);

        // Everything reads zero out of reset.
        for (int k = 0; k < 16; k++) idle(k[3:0], k[3:0]);

        // Write 0 then 67 to register 1; forwarded in the write cycle on config A only.
        step(0, 1, 1, 0, 0, 0, 0, 1, 1);
        step(0, 1, 1, 67, 0, 0, 0, 1, 1);
        idle(1, 1);

        // Collision on register 3: port 1 data kept, flag high one cycle.
        step(0, 1, 3, 16'h00AA, 1, 3, 16'h0055, 3, 3);
        idle(3, 3);
        idle(3, 3);

        // Register 0 ignores writes while the concurrent port 2 write lands at 5.
        step(0, 1, 0, 16'h00FF, 1, 5, 16'h0012, 0, 5);
        idle(0, 5);

        // Collision on address 0 still raises the flag.
        step(0, 1, 0, 16'h0011, 1, 0, 16'h0022, 0, 0);
        idle(0, 0);

        // Fill, then reset with a pending write: all cleared, write dropped.
        for (int i = 0; i < 8; i++) step(0, 1, i[3:0], 16'(10 + i), 0, 0, 0, i[3:0], 0);
        for (int i = 0; i < 8; i++) idle(i[3:0], 4'(7 - i));
        step(1, 1, 2, 99, 0, 0, 0, 2, 3);
        for (int i = 0; i < 8; i++) idle(i[3:0], 2);

        // Top address of config B: old value during the write, new value after.
        step(0, 1, 15, 16'h1234, 0, 0, 0, 15, 15);
        step(0, 1, 15, 16'hBEEF, 0, 0, 0, 15, 15);
        idle(15, 15);

        for (int n = 0; n < 400; n++) begin
            logic [3:0] a1, a2;
            a1 = 4'($urandom);
            a2 = ($urandom_range(0, 3) == 0) ? a1 : 4'($urandom);
            step(($urandom_range(0, 31) == 0), 1'($urandom), a1, 16'($urandom),
                 1'($urandom), a2, 16'($urandom),
                 ($urandom_range(0, 2) == 0) ? a1 : 4'($urandom),
                 ($urandom_range(0, 2) == 0) ? a2 : 4'($urandom));
        end
        idle(0, 0);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 16'(sb.size()), 16'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
